// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline stall/flush sequencer.
// Used by pipeline_ctrl (top) and load_use_detect.
package pipe_ctrl_pkg;

  // Sequencer states; the encoding is visible on the ctrl_state debug port.
  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_e;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  localparam logic [4:0] REG_X0 = 5'd0;

  // The six pipeline-register controls, bundled for top-level wiring.
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_bubble;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_IDLE = '0;

  // Whole-pipe freeze while data memory is busy; MEM/WB receives a bubble.
  function automatic pipe_ctl_t ctl_freeze();
    pipe_ctl_t c;
    c               = CTL_IDLE;
    c.pc_stall      = 1'b1;
    c.if_id_stall   = 1'b1;
    c.ex_mem_stall  = 1'b1;
    c.mem_wb_bubble = 1'b1;
    return c;
  endfunction

  // Squash the two wrong-path instructions in IF/ID and ID/EX.
  function automatic pipe_ctl_t ctl_squash();
    pipe_ctl_t c;
    c             = CTL_IDLE;
    c.if_id_flush = 1'b1;
    c.id_ex_flush = 1'b1;
    return c;
  endfunction

  // Hold the front end one cycle and insert a single bubble into EX.
  function automatic pipe_ctl_t ctl_bubble();
    pipe_ctl_t c;
    c             = CTL_IDLE;
    c.pc_stall    = 1'b1;
    c.if_id_stall = 1'b1;
    c.id_ex_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard comparator. Flags when the
// instruction in ID reads a register that the load currently in EX will write,
// a case the forwarding unit cannot cover.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_ex_rd_addr,
  input  logic       id_ex_memread,
  output logic       load_use
);

  logic [4:0] src_addr [2];
  logic [1:0] src_used;
  logic [1:0] src_hit;

  assign src_addr[0] = id_rs1_addr;
  assign src_addr[1] = id_rs2_addr;
  assign src_used    = {id_uses_rs2, id_uses_rs1};

  // One comparator per source operand of the ID instruction.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_hit[gi] = src_used[gi] & (src_addr[gi] == id_ex_rd_addr);
  end

  assign load_use = id_ex_memread & (id_ex_rd_addr != REG_X0) & (|src_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Optional feature macro: PIPE_PERF_CNT_EN adds perf_stall_cycles and
// perf_flush_count counters/ports; without it the design has neither.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_ex_rd_addr,
  input  logic       id_ex_memread,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       dmem_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_stall,
  output logic       mem_wb_bubble,
  output logic [1:0] ctrl_state,
  output logic       mem_timeout_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
`endif
);

  localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(MEM_TIMEOUT);

  ctrl_state_e          state_reg, state_next;
  pipe_ctl_t            ctl;
  logic                 load_use;
  logic                 memstall;
  logic                 wd_active;
  logic [TIMEOUT_W-1:0] wd_count_reg, wd_count_next;
  logic                 timeout_err_reg;

  load_use_detect u_load_use_detect (
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .id_ex_rd_addr (id_ex_rd_addr),
    .id_ex_memread (id_ex_memread),
    .load_use      (load_use)
  );

  // A dropped mem_req counts as completion, so only an outstanding request stalls.
  assign memstall = mem_req & ~dmem_ready;

  // State register; reset forces a one-cycle INIT flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= INIT;
    else        state_reg <= state_next;
  end

  // Next-state: stay in MEM_WAIT while the access is outstanding, else run.
  always_comb begin
    state_next = RUN;
    case (state_reg)
      INIT:     state_next = RUN;
      RUN:      state_next = memstall ? MEM_WAIT : RUN;
      MEM_WAIT: state_next = memstall ? MEM_WAIT : RUN;
      default:  state_next = RUN;
    endcase
  end

  // Outputs: memory freeze beats redirect squash beats load-use bubble. The
  // ready cycle out of MEM_WAIT applies any redirect/hazard held during the freeze.
  always_comb begin
    ctl = CTL_IDLE;
    case (state_reg)
      INIT: ctl = ctl_squash();
      RUN, MEM_WAIT: begin
        if (memstall)         ctl = ctl_freeze();
        else if (ex_redirect) ctl = ctl_squash();
        else if (load_use)    ctl = ctl_bubble();
      end
      default: ctl = CTL_IDLE;
    endcase
  end

  // Watchdog counts consecutive MEM_WAIT stall cycles and saturates at the limit.
  assign wd_active = (state_reg == MEM_WAIT) & memstall;

  always_comb begin
    wd_count_next = '0;
    if (wd_active) begin
      wd_count_next = (wd_count_reg == WD_LIMIT) ? wd_count_reg
                                                 : wd_count_reg + TIMEOUT_W'(1);
    end
  end

  // Watchdog counter and sticky timeout flag; only reset clears the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_count_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      wd_count_reg <= wd_count_next;
      if (wd_active && (wd_count_next == WD_LIMIT)) timeout_err_reg <= 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_flush_reg;
  logic        redirect_flush;

  // Only a redirect squash counts as a flush; the INIT flush does not.
  assign redirect_flush = ((state_reg == RUN) | (state_reg == MEM_WAIT))
                        & ~memstall & ex_redirect;

  // Free-running performance counters, wrapping modulo 2**32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_reg <= '0;
      perf_flush_reg <= '0;
    end else begin
      if (ctl.pc_stall) perf_stall_reg <= perf_stall_reg + 32'd1;
      if (redirect_flush) perf_flush_reg <= perf_flush_reg + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_reg;
  assign perf_flush_count  = perf_flush_reg;
`endif

  assign pc_stall        = ctl.pc_stall;
  assign if_id_stall     = ctl.if_id_stall;
  assign if_id_flush     = ctl.if_id_flush;
  assign id_ex_flush     = ctl.id_ex_flush;
  assign ex_mem_stall    = ctl.ex_mem_stall;
  assign mem_wb_bubble   = ctl.mem_wb_bubble;
  assign ctrl_state      = state_reg;
  assign mem_timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios plus randomized stimulus checked
// against a cycle-level behavioural model of the sequencer rules.
module tb_pipeline_ctrl;

  localparam int TW = 8;
  localparam int TO = 10;

  // Expected control vectors: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_wb_bubble}
  localparam logic [5:0] C_NONE   = 6'b000000;
  localparam logic [5:0] C_FREEZE = 6'b110011;
  localparam logic [5:0] C_SQUASH = 6'b001100;
  localparam logic [5:0] C_LU     = 6'b110100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_ex_rd_addr;
  logic       id_uses_rs1, id_uses_rs2, id_ex_memread;
  logic       ex_redirect, mem_req, dmem_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush;
  logic       ex_mem_stall, mem_wb_bubble, mem_timeout_err;
  logic [1:0] ctrl_state;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  logic [5:0] ctl;
  assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_wb_bubble};

  pipeline_ctrl #(.TIMEOUT_W(TW), .MEM_TIMEOUT(TO)) dut (
`ifdef PIPE_PERF_CNT_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count),
`endif
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_ex_rd_addr   (id_ex_rd_addr),
    .id_ex_memread   (id_ex_memread),
    .ex_redirect     (ex_redirect),
    .mem_req         (mem_req),
    .dmem_ready      (dmem_ready),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_stall    (ex_mem_stall),
    .mem_wb_bubble   (mem_wb_bubble),
    .ctrl_state      (ctrl_state),
    .mem_timeout_err (mem_timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: "starting up", "waiting on memory", length of the wait, sticky error.
  bit          m_init;
  bit          m_waiting;
  int          m_wait;
  bit          m_err;
  int unsigned m_stall_cnt;
  int unsigned m_flush_cnt;

  function automatic void model_reset();
    m_init = 1; m_waiting = 0; m_wait = 0; m_err = 0;
    m_stall_cnt = 0; m_flush_cnt = 0;
  endfunction

  function automatic bit model_hazard();
    bit hit;
    hit = 0;
    if (id_uses_rs1 && id_rs1_addr == id_ex_rd_addr) hit = 1;
    if (id_uses_rs2 && id_rs2_addr == id_ex_rd_addr) hit = 1;
    return id_ex_memread && (id_ex_rd_addr != 0) && hit;
  endfunction

  function automatic logic [5:0] model_ctl();
    if (m_init) return C_SQUASH;
    if (mem_req && !dmem_ready) return C_FREEZE;
    if (ex_redirect) return C_SQUASH;
    if (model_hazard()) return C_LU;
    return C_NONE;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_init) return 2'd0;
    return m_waiting ? 2'd2 : 2'd1;
  endfunction

  // Advance the model by one clock edge using the inputs of the cycle that ends.
  function automatic void model_tick();
    logic [5:0] e;
    bit stalled;
    if (!rst_n) begin model_reset(); return; end
    e = model_ctl();
    stalled = mem_req && !dmem_ready;
    if (e[5]) m_stall_cnt++;
    if (!m_init && !stalled && ex_redirect) m_flush_cnt++;
    if (m_init) m_init = 0;
    else if (stalled) begin
      if (m_waiting && m_wait < TO) m_wait++;
      m_waiting = 1;
    end else begin
      m_waiting = 0; m_wait = 0;
    end
    if (m_wait >= TO) m_err = 1;
  endfunction

  task automatic set_idle();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_ex_rd_addr = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_ex_memread = 1'b0;
    ex_redirect = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Clock edge: log the cycle, step the model, release inputs shortly after.
  task automatic advance();
    @(posedge clk);
    $display("t=%0t rst_n=%b st=%0d ctl=%b err=%b", $time, rst_n, ctrl_state, ctl, mem_timeout_err);
    model_tick();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (ctl !== C_SQUASH || ctrl_state !== 2'd0 || mem_timeout_err !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: ctl=%b st=%0d err=%b required ctl=%b st=0 err=0", ctl, ctrl_state, mem_timeout_err, C_SQUASH);
      end
      advance();
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_SQUASH || ctrl_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_init_flush: ctl=%b st=%0d required ctl=%b st=0", ctl, ctrl_state, C_SQUASH);
    end
    advance();
    @(negedge clk);
    n_checks++;
    if (ctl !== C_NONE || ctrl_state !== 2'd1) begin
      n_fail++;
      $display("FAIL reset_to_run: ctl=%b st=%0d required ctl=%b st=1", ctl, ctrl_state, C_NONE);
    end
    advance();
  endtask

  task automatic test_load_use();
    logic [5:0] exp_ctl [5];
    set_idle();
    for (int c = 0; c < 5; c++) begin
      set_idle();
      id_ex_memread = 1'b1; id_ex_rd_addr = 5'd5; id_rs1_addr = 5'd7; id_uses_rs1 = 1'b1;
      id_rs2_addr = 5'd5; id_uses_rs2 = 1'b1;
      exp_ctl[c] = C_LU;
      case (c)
        1: begin id_ex_memread = 1'b0; exp_ctl[c] = C_NONE; end        // load has moved on
        2: begin id_ex_rd_addr = 5'd0; id_rs2_addr = 5'd0; exp_ctl[c] = C_NONE; end
        3: begin id_uses_rs2 = 1'b0; exp_ctl[c] = C_NONE; end
        4: begin id_uses_rs2 = 1'b0; id_rs1_addr = 5'd5; end            // rs1 match
        default: ;
      endcase
      @(negedge clk);
      n_checks++;
      if (ctl !== exp_ctl[c] || ctrl_state !== 2'd1) begin
        n_fail++;
        $display("FAIL load_use_%0d: ctl=%b st=%0d required ctl=%b st=1", c, ctl, ctrl_state, exp_ctl[c]);
      end
      advance();
    end
    set_idle();
  endtask

  task automatic test_mem_wait();
    set_idle();
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (ctl !== C_FREEZE || ctrl_state !== (c == 0 ? 2'd1 : 2'd2)) begin
        n_fail++;
        $display("FAIL mem_wait_%0d: ctl=%b st=%0d required ctl=%b st=%0d", c, ctl, ctrl_state, C_FREEZE, (c == 0 ? 1 : 2));
      end
      advance();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_NONE || ctrl_state !== 2'd2) begin
      n_fail++;
      $display("FAIL mem_ready: ctl=%b st=%0d required ctl=%b st=2", ctl, ctrl_state, C_NONE);
    end
    advance();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (ctl !== C_NONE || ctrl_state !== 2'd1) begin
      n_fail++;
      $display("FAIL mem_back_run: ctl=%b st=%0d required ctl=%b st=1", ctl, ctrl_state, C_NONE);
    end
    advance();
    // mem_req dropping mid-wait behaves like ready
    mem_req = 1'b1; dmem_ready = 1'b0;
    advance(); advance();
    mem_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_NONE || ctrl_state !== 2'd2) begin
      n_fail++;
      $display("FAIL mem_abort: ctl=%b st=%0d required ctl=%b st=2", ctl, ctrl_state, C_NONE);
    end
    advance();
    @(negedge clk);
    n_checks++;
    if (ctrl_state !== 2'd1) begin
      n_fail++;
      $display("FAIL mem_abort_run: st=%0d required st=1", ctrl_state);
    end
    advance();
    // asynchronous reset in the middle of a wait
    mem_req = 1'b1; dmem_ready = 1'b0;
    advance(); advance();
    rst_n = 1'b0; model_reset();
    #1;
    n_checks++;
    if (ctrl_state !== 2'd0 || ctl !== C_SQUASH) begin
      n_fail++;
      $display("FAIL mem_async_reset: st=%0d ctl=%b required st=0 ctl=%b", ctrl_state, ctl, C_SQUASH);
    end
    advance();
    set_idle(); rst_n = 1'b1;
    advance();
  endtask

  task automatic test_redirect_behind_wait();
    set_idle();
    mem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (ctl !== C_FREEZE) begin
        n_fail++;
        $display("FAIL redir_hidden_%0d: ctl=%b required %b", c, ctl, C_FREEZE);
      end
      advance();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_SQUASH) begin
      n_fail++;
      $display("FAIL redir_on_ready: ctl=%b required %b", ctl, C_SQUASH);
    end
    advance();
    // a load-use held frozen is applied in the ready cycle
    set_idle();
    mem_req = 1'b1; id_ex_memread = 1'b1; id_ex_rd_addr = 5'd9; id_rs1_addr = 5'd9; id_uses_rs1 = 1'b1;
    advance(); advance();
    dmem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_LU || ctrl_state !== 2'd2) begin
      n_fail++;
      $display("FAIL lu_on_ready: ctl=%b st=%0d required ctl=%b st=2", ctl, ctrl_state, C_LU);
    end
    advance();
    set_idle();
    advance();
  endtask

  task automatic test_redirect_lu();
    set_idle();
    ex_redirect = 1'b1; id_ex_memread = 1'b1; id_ex_rd_addr = 5'd3; id_rs2_addr = 5'd3; id_uses_rs2 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_SQUASH || pc_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_lu: ctl=%b pc_stall=%b required ctl=%b pc_stall=0", ctl, pc_stall, C_SQUASH);
    end
    advance();
    set_idle();
  endtask

  task automatic test_watchdog();
    set_idle();
    rst_n = 1'b0; model_reset();
    advance();
    rst_n = 1'b1;
    advance();
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      n_checks++;
      if (ctl !== C_FREEZE || mem_timeout_err !== m_err) begin
        n_fail++;
        $display("FAIL wd_cycle_%0d: ctl=%b err=%b required ctl=%b err=%b", c, ctl, mem_timeout_err, C_FREEZE, m_err);
      end
      if (c == 5 || c == 15) begin
        n_checks++;
        if (mem_timeout_err !== (c == 15)) begin
          n_fail++;
          $display("FAIL wd_level_%0d: err=%b required %b", c, mem_timeout_err, (c == 15));
        end
      end
      advance();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_NONE || mem_timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_ready: ctl=%b err=%b required ctl=%b err=1", ctl, mem_timeout_err, C_NONE);
    end
`ifdef PIPE_PERF_CNT_EN
    n_checks++;
    if (perf_stall_cycles !== 32'd15) begin
      n_fail++;
      $display("FAIL wd_perf_stall: got %0d required 15", perf_stall_cycles);
    end
`endif
    advance();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (mem_timeout_err !== 1'b1 || ctrl_state !== 2'd1) begin
      n_fail++;
      $display("FAIL wd_sticky: err=%b st=%0d required err=1 st=1", mem_timeout_err, ctrl_state);
    end
    advance();
  endtask

  task automatic test_random();
    logic [5:0] exp_ctl;
    logic [1:0] exp_st;
    for (int c = 0; c < 400; c++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(99) == 0) begin rst_n = 1'b0; model_reset(); end
      id_rs1_addr   = 5'($urandom_range(3));
      id_rs2_addr   = 5'($urandom_range(3));
      id_ex_rd_addr = 5'($urandom_range(3));
      id_uses_rs1   = 1'($urandom_range(1));
      id_uses_rs2   = 1'($urandom_range(1));
      id_ex_memread = 1'($urandom_range(1));
      ex_redirect   = ($urandom_range(4) == 0);
      mem_req       = ($urandom_range(9) < 4);
      dmem_ready    = ($urandom_range(2) == 0);
      @(negedge clk);
      exp_ctl = model_ctl();
      exp_st  = model_state();
      n_checks++;
      if (ctl !== exp_ctl || ctrl_state !== exp_st || mem_timeout_err !== m_err) begin
        n_fail++;
        $display("FAIL rand_%0d: ctl=%b st=%0d err=%b required ctl=%b st=%0d err=%b",
                 c, ctl, ctrl_state, mem_timeout_err, exp_ctl, exp_st, m_err);
      end
      n_checks++;
      if (((if_id_stall & if_id_flush) | (ex_mem_stall & id_ex_flush)) !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_excl_%0d: ctl=%b required no stall+flush on one register", c, ctl);
      end
`ifdef PIPE_PERF_CNT_EN
      n_checks++;
      if (perf_stall_cycles !== m_stall_cnt || perf_flush_count !== m_flush_cnt) begin
        n_fail++;
        $display("FAIL rand_perf_%0d: stall=%0d flush=%0d required stall=%0d flush=%0d",
                 c, perf_stall_cycles, perf_flush_count, m_stall_cnt, m_flush_cnt);
      end
`endif
      advance();
    end
    rst_n = 1'b1;
    set_idle();
  endtask

  initial begin
    set_idle();
    rst_n = 1'b1;
    model_reset();
    #1;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_redirect_behind_wait();
    test_redirect_lu();
    test_watchdog();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "time limit");
  end

endmodule
